// File: rtl/axi_preid_pkg.sv
// axi_preid_pkg
// Shared helpers for the prepended-ID slot scheduler.
//   getPreIdWidth(n) : width of a slot index for n slots (at least 1 bit)
//   getCountWidth(n) : width needed to hold an outstanding count of 0..n
package axi_preid_pkg;

    // A single slot still needs one bit so that the preid ports exist.
    function automatic int getPreIdWidth(input int parallelNum);
        return (parallelNum == 1) ? 1 : $clog2(parallelNum);
    endfunction

    // The count must reach parallelNum itself, hence the +1.
    function automatic int getCountWidth(input int parallelNum);
        return $clog2(parallelNum + 1);
    endfunction

endpackage

// File: rtl/axi_preid_scheduler_slot_alloc.sv
// axi_preid_slot_alloc
// One direction of the prepended-ID scheduler. It keeps a busy bit per slot,
// grants the first free slot round-robin from a moving pointer, and holds the
// granted slot stable while the downstream address channel back-pressures.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   slv_valid_i/slv_ready_o  upstream address handshake
//   mst_valid_o/mst_ready_i  downstream address handshake
//   preid_o                  slot index attached to the outgoing address
//   rel_i, rel_preid_i       burst completion strobe and the slot it frees
//   busy_o, count_o, idle_o  per-slot busy vector, outstanding count, count==0
//   err_o                    sticky flag: release of a slot that was not busy
module axi_preid_slot_alloc
    import axi_preid_pkg::*;
#(
    parameter int ParallelNum = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      slv_valid_i,
    output logic                                      slv_ready_o,
    output logic                                      mst_valid_o,
    input  logic                                      mst_ready_i,
    output logic [getPreIdWidth(ParallelNum)-1:0]     preid_o,
    input  logic                                      rel_i,
    input  logic [getPreIdWidth(ParallelNum)-1:0]     rel_preid_i,
    output logic [ParallelNum-1:0]                    busy_o,
    output logic [getCountWidth(ParallelNum)-1:0]     count_o,
    output logic                                      idle_o,
    output logic                                      err_o
);

    localparam int PreIdWidth = getPreIdWidth(ParallelNum);
    localparam int CountWidth = getCountWidth(ParallelNum);

    logic [ParallelNum-1:0] busy_q, busy_d;
    logic [PreIdWidth-1:0]  ptr_q, ptr_d;
    logic                   lock_q, lock_d;
    logic [PreIdWidth-1:0]  lockSlot_q, lockSlot_d;
    logic                   err_q, err_d;

    logic                   candFound;
    logic [PreIdWidth-1:0]  candSlot;
    logic                   selValid;
    logic [PreIdWidth-1:0]  selSlot;
    logic                   handshake;
    logic                   relInRange;
    logic                   relHit;
    logic [CountWidth-1:0]  busyCount;

    // Slot arithmetic wraps at ParallelNum, which need not be a power of two.
    function automatic logic [PreIdWidth-1:0] wrapAdd(
        input logic [PreIdWidth-1:0] base,
        input int unsigned           offset
    );
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= 32'(ParallelNum)) begin
            sum = sum - 32'(ParallelNum);
        end
        return PreIdWidth'(sum);
    endfunction

    // Round-robin search for the first free slot starting at the pointer.
    always_comb begin
        candFound = 1'b0;
        candSlot  = ptr_q;
        for (int i = 0; i < ParallelNum; i++) begin
            if (!candFound && !busy_q[wrapAdd(ptr_q, i)]) begin
                candFound = 1'b1;
                candSlot  = wrapAdd(ptr_q, i);
            end
        end
    end

    // A locked slot wins over the search so preid stays put while valid waits.
    assign selValid = lock_q | candFound;
    assign selSlot  = lock_q ? lockSlot_q : candSlot;

    assign mst_valid_o = ~rst_i & selValid & slv_valid_i;
    assign slv_ready_o = ~rst_i & selValid & mst_ready_i;
    assign preid_o     = rst_i ? '0 : (selValid ? selSlot : ptr_q);
    assign handshake   = mst_valid_o & mst_ready_i;

    // Out-of-range or idle-slot releases are flagged instead of applied.
    assign relInRange = 32'(rel_preid_i) < 32'(ParallelNum);
    assign relHit     = relInRange && busy_q[rel_preid_i];

    // Next-state: release first, then allocation; they never target the same
    // slot because allocation only picks free slots.
    always_comb begin
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lockSlot_d = lockSlot_q;
        err_d      = err_q;
        if (rel_i) begin
            if (relHit) begin
                busy_d[rel_preid_i] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (handshake) begin
            busy_d[selSlot] = 1'b1;
            ptr_d           = wrapAdd(selSlot, 1);
            lock_d          = 1'b0;
        end else if (mst_valid_o) begin
            lock_d     = 1'b1;
            lockSlot_d = selSlot;
        end
    end

    // State registers with synchronous reset that drops all outstanding bursts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lockSlot_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lockSlot_q <= lockSlot_d;
            err_q      <= err_d;
        end
    end

    // Outstanding count is a popcount of the registered busy bits.
    always_comb begin
        busyCount = '0;
        for (int i = 0; i < ParallelNum; i++) begin
            busyCount = busyCount + CountWidth'(busy_q[i]);
        end
    end

    // Status is forced to its reset view in any cycle reset is asserted.
    assign busy_o  = rst_i ? '0 : busy_q;
    assign count_o = rst_i ? '0 : busyCount;
    assign idle_o  = (count_o == '0);
    assign err_o   = ~rst_i & err_q;

endmodule

// File: rtl/axi_preid_scheduler.sv
// axi_preid_scheduler
// Allocates prepended-ID slots for AR and AW so two outstanding bursts never
// share a prepended ID. Reads are released by the last R beat, writes by the
// B response. Each direction is an independent axi_preid_slot_alloc.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   slv_ar_*/mst_ar_*, ar_preid_o        AR passthrough handshake and slot
//   slv_aw_*/mst_aw_*, aw_preid_o        AW passthrough handshake and slot
//   r_valid_i/r_ready_i/r_last_i/r_preid_i  R channel monitor
//   b_valid_i/b_ready_i/b_preid_i        B channel monitor
//   rd_/wr_busy_o, rd_/wr_count_o, rd_/wr_idle_o  per-direction status
//   err_o                                sticky bad-release flag (either path)
module axi_preid_scheduler
    import axi_preid_pkg::*;
#(
    parameter int ParallelNum = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  slv_ar_valid_i,
    output logic                                  slv_ar_ready_o,
    output logic                                  mst_ar_valid_o,
    input  logic                                  mst_ar_ready_i,
    output logic [getPreIdWidth(ParallelNum)-1:0] ar_preid_o,
    input  logic                                  slv_aw_valid_i,
    output logic                                  slv_aw_ready_o,
    output logic                                  mst_aw_valid_o,
    input  logic                                  mst_aw_ready_i,
    output logic [getPreIdWidth(ParallelNum)-1:0] aw_preid_o,
    input  logic                                  r_valid_i,
    input  logic                                  r_ready_i,
    input  logic                                  r_last_i,
    input  logic [getPreIdWidth(ParallelNum)-1:0] r_preid_i,
    input  logic                                  b_valid_i,
    input  logic                                  b_ready_i,
    input  logic [getPreIdWidth(ParallelNum)-1:0] b_preid_i,
    output logic [ParallelNum-1:0]                rd_busy_o,
    output logic [ParallelNum-1:0]                wr_busy_o,
    output logic [getCountWidth(ParallelNum)-1:0] rd_count_o,
    output logic [getCountWidth(ParallelNum)-1:0] wr_count_o,
    output logic                                  rd_idle_o,
    output logic                                  wr_idle_o,
    output logic                                  err_o
);

    logic rdRelease;
    logic wrRelease;
    logic rdErr;
    logic wrErr;

    // A read burst finishes on its last R beat; a write on its B response.
    assign rdRelease = r_valid_i & r_ready_i & r_last_i;
    assign wrRelease = b_valid_i & b_ready_i;

    axi_preid_slot_alloc #(
        .ParallelNum (ParallelNum)
    ) i_rd_alloc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .slv_valid_i (slv_ar_valid_i),
        .slv_ready_o (slv_ar_ready_o),
        .mst_valid_o (mst_ar_valid_o),
        .mst_ready_i (mst_ar_ready_i),
        .preid_o     (ar_preid_o),
        .rel_i       (rdRelease),
        .rel_preid_i (r_preid_i),
        .busy_o      (rd_busy_o),
        .count_o     (rd_count_o),
        .idle_o      (rd_idle_o),
        .err_o       (rdErr)
    );

    axi_preid_slot_alloc #(
        .ParallelNum (ParallelNum)
    ) i_wr_alloc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .slv_valid_i (slv_aw_valid_i),
        .slv_ready_o (slv_aw_ready_o),
        .mst_valid_o (mst_aw_valid_o),
        .mst_ready_i (mst_aw_ready_i),
        .preid_o     (aw_preid_o),
        .rel_i       (wrRelease),
        .rel_preid_i (b_preid_i),
        .busy_o      (wr_busy_o),
        .count_o     (wr_count_o),
        .idle_o      (wr_idle_o),
        .err_o       (wrErr)
    );

    assign err_o = rdErr | wrErr;

endmodule

// File: tb/tb_axi_preid_scheduler.sv
// tb_axi_preid_scheduler
// Directed bench for axi_preid_scheduler with four slots per direction.
// Inputs change 1 time unit after each rising edge; outputs are checked
// 2 time units after the edge, well clear of the next edge.
module tb_axi_preid_scheduler;

    localparam int N = 4;

    logic       clk_i;
    logic       rst_i;
    logic       slv_ar_valid_i;
    logic       slv_ar_ready_o;
    logic       mst_ar_valid_o;
    logic       mst_ar_ready_i;
    logic [1:0] ar_preid_o;
    logic       slv_aw_valid_i;
    logic       slv_aw_ready_o;
    logic       mst_aw_valid_o;
    logic       mst_aw_ready_i;
    logic [1:0] aw_preid_o;
    logic       r_valid_i;
    logic       r_ready_i;
    logic       r_last_i;
    logic [1:0] r_preid_i;
    logic       b_valid_i;
    logic       b_ready_i;
    logic [1:0] b_preid_i;
    logic [3:0] rd_busy_o;
    logic [3:0] wr_busy_o;
    logic [2:0] rd_count_o;
    logic [2:0] wr_count_o;
    logic       rd_idle_o;
    logic       wr_idle_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    axi_preid_scheduler #(
        .ParallelNum (N)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .mst_ar_valid_o (mst_ar_valid_o),
        .mst_ar_ready_i (mst_ar_ready_i),
        .ar_preid_o     (ar_preid_o),
        .slv_aw_valid_i (slv_aw_valid_i),
        .slv_aw_ready_o (slv_aw_ready_o),
        .mst_aw_valid_o (mst_aw_valid_o),
        .mst_aw_ready_i (mst_aw_ready_i),
        .aw_preid_o     (aw_preid_o),
        .r_valid_i      (r_valid_i),
        .r_ready_i      (r_ready_i),
        .r_last_i       (r_last_i),
        .r_preid_i      (r_preid_i),
        .b_valid_i      (b_valid_i),
        .b_ready_i      (b_ready_i),
        .b_preid_i      (b_preid_i),
        .rd_busy_o      (rd_busy_o),
        .wr_busy_o      (wr_busy_o),
        .rd_count_o     (rd_count_o),
        .wr_count_o     (wr_count_o),
        .rd_idle_o      (rd_idle_o),
        .wr_idle_o      (wr_idle_o),
        .err_o          (err_o)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Move to the drive point just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Drive both address channels and let the combinational paths settle.
    task automatic applyStimulus(input logic arV, input logic arR,
                                 input logic awV, input logic awR);
        slv_ar_valid_i = arV;
        mst_ar_ready_i = arR;
        slv_aw_valid_i = awV;
        mst_aw_ready_i = awR;
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence covering allocation, stall, lock, release,
    // error and reset behaviour.
    initial begin
        rst_i     = 1'b1;
        r_valid_i = 1'b0;
        r_ready_i = 1'b1;
        r_last_i  = 1'b0;
        r_preid_i = 2'd0;
        b_valid_i = 1'b0;
        b_ready_i = 1'b1;
        b_preid_i = 2'd0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) nextCycle();
        $display("[TB] reset state");
        checkOutput("rst_ar_valid", 32'(mst_ar_valid_o), 32'd0);
        checkOutput("rst_ar_ready", 32'(slv_ar_ready_o), 32'd0);
        checkOutput("rst_aw_valid", 32'(mst_aw_valid_o), 32'd0);
        checkOutput("rst_ar_preid", 32'(ar_preid_o), 32'd0);
        checkOutput("rst_rd_count", 32'(rd_count_o), 32'd0);
        checkOutput("rst_rd_idle", 32'(rd_idle_o), 32'd1);
        checkOutput("rst_err", 32'(err_o), 32'd0);

        $display("[TB] four back-to-back reads then stall");
        nextCycle();
        rst_i = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_preid0", 32'(ar_preid_o), 32'd0);
        checkOutput("t1_valid0", 32'(mst_ar_valid_o), 32'd1);
        checkOutput("t1_ready0", 32'(slv_ar_ready_o), 32'd1);
        for (int k = 1; k < 4; k++) begin
            nextCycle();
            #1;
            checkOutput("t1_preid", 32'(ar_preid_o), 32'(k));
            checkOutput("t1_count", 32'(rd_count_o), 32'(k));
        end
        nextCycle();
        #1;
        checkOutput("t1_full_ready", 32'(slv_ar_ready_o), 32'd0);
        checkOutput("t1_full_valid", 32'(mst_ar_valid_o), 32'd0);
        checkOutput("t1_full_count", 32'(rd_count_o), 32'd4);
        checkOutput("t1_full_busy", 32'(rd_busy_o), 32'hF);
        checkOutput("t1_full_preid", 32'(ar_preid_o), 32'd0);

        $display("[TB] release slot 2 while full");
        nextCycle();
        r_valid_i = 1'b1;
        r_last_i  = 1'b1;
        r_preid_i = 2'd2;
        #1;
        checkOutput("t2_no_bypass", 32'(mst_ar_valid_o), 32'd0);
        nextCycle();
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
        #1;
        checkOutput("t2_busy", 32'(rd_busy_o), 32'hB);
        checkOutput("t2_preid", 32'(ar_preid_o), 32'd2);
        checkOutput("t2_valid", 32'(mst_ar_valid_o), 32'd1);
        checkOutput("t2_ready", 32'(slv_ar_ready_o), 32'd1);
        nextCycle();
        #1;
        checkOutput("t2_count", 32'(rd_count_o), 32'd4);
        checkOutput("t2_stall", 32'(mst_ar_valid_o), 32'd0);
        checkOutput("t2_ptr", 32'(ar_preid_o), 32'd3);

        $display("[TB] preid held under back-pressure");
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        r_valid_i = 1'b1;
        r_last_i  = 1'b1;
        r_preid_i = 2'd1;
        nextCycle();
        r_preid_i = 2'd2;
        nextCycle();
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
        #1;
        checkOutput("t3_busy_pre", 32'(rd_busy_o), 32'h9);
        checkOutput("t3_count_pre", 32'(rd_count_o), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_preid_start", 32'(ar_preid_o), 32'd1);
        checkOutput("t3_ready_low", 32'(slv_ar_ready_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            if (k == 0) begin
                r_valid_i = 1'b1;
                r_last_i  = 1'b1;
                r_preid_i = 2'd0;
            end else begin
                r_valid_i = 1'b0;
                r_last_i  = 1'b0;
            end
            #1;
            checkOutput("t3_preid_hold", 32'(ar_preid_o), 32'd1);
            checkOutput("t3_valid_hold", 32'(mst_ar_valid_o), 32'd1);
        end
        checkOutput("t3_busy_freed", 32'(rd_busy_o), 32'h8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_hs_preid", 32'(ar_preid_o), 32'd1);
        checkOutput("t3_hs_ready", 32'(slv_ar_ready_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_busy_post", 32'(rd_busy_o), 32'hA);
        checkOutput("t3_count_post", 32'(rd_count_o), 32'd2);
        checkOutput("t3_next_preid", 32'(ar_preid_o), 32'd2);

        $display("[TB] simultaneous write grant and release");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_aw_preid0", 32'(aw_preid_o), 32'd0);
        checkOutput("t4_aw_valid0", 32'(mst_aw_valid_o), 32'd1);
        nextCycle();
        b_valid_i = 1'b1;
        b_preid_i = 2'd0;
        #1;
        checkOutput("t4_wr_busy_pre", 32'(wr_busy_o), 32'h1);
        checkOutput("t4_aw_preid1", 32'(aw_preid_o), 32'd1);
        checkOutput("t4_wr_count_pre", 32'(wr_count_o), 32'd1);
        nextCycle();
        b_valid_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_wr_busy_post", 32'(wr_busy_o), 32'h2);
        checkOutput("t4_wr_count_post", 32'(wr_count_o), 32'd1);
        checkOutput("t4_aw_preid2", 32'(aw_preid_o), 32'd2);
        checkOutput("t4_aw_valid_low", 32'(mst_aw_valid_o), 32'd0);
        checkOutput("t4_err_clear", 32'(err_o), 32'd0);

        $display("[TB] release of idle write slot");
        b_valid_i = 1'b1;
        b_preid_i = 2'd3;
        #1;
        checkOutput("t5_err_before", 32'(err_o), 32'd0);
        nextCycle();
        b_valid_i = 1'b0;
        #1;
        checkOutput("t5_err_set", 32'(err_o), 32'd1);
        checkOutput("t5_wr_busy", 32'(wr_busy_o), 32'h2);
        nextCycle();
        #1;
        checkOutput("t5_err_sticky", 32'(err_o), 32'd1);

        $display("[TB] reset with three reads outstanding");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_preid_third", 32'(ar_preid_o), 32'd2);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_count3", 32'(rd_count_o), 32'd3);
        checkOutput("t6_busy3", 32'(rd_busy_o), 32'hE);
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_rst_busy", 32'(rd_busy_o), 32'h0);
        checkOutput("t6_rst_count", 32'(rd_count_o), 32'd0);
        checkOutput("t6_rst_idle", 32'(rd_idle_o), 32'd1);
        checkOutput("t6_rst_valid", 32'(mst_ar_valid_o), 32'd0);
        checkOutput("t6_rst_err", 32'(err_o), 32'd0);
        nextCycle();
        rst_i = 1'b0;
        #1;
        checkOutput("t6_post_preid", 32'(ar_preid_o), 32'd0);
        checkOutput("t6_post_valid", 32'(mst_ar_valid_o), 32'd1);
        checkOutput("t6_post_busy", 32'(rd_busy_o), 32'h0);
        checkOutput("t6_post_idle", 32'(rd_idle_o), 32'd1);
        checkOutput("t6_post_err", 32'(err_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        r_valid_i = 1'b1;
        r_last_i  = 1'b1;
        r_preid_i = 2'd2;
        #1;
        checkOutput("t6_grant_busy", 32'(rd_busy_o), 32'h1);
        checkOutput("t6_err_still0", 32'(err_o), 32'd0);
        nextCycle();
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
        #1;
        checkOutput("t6_stale_err", 32'(err_o), 32'd1);
        checkOutput("t6_stale_busy", 32'(rd_busy_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
